// File: rtl/lut_1596_pkg.sv
// Shared constants and state encoding for the lut_1596 preimage scanner.
package lut_1596_pkg;
   localparam int         XW       = 4;
   localparam int         CNT_W    = 5;
   localparam logic [3:0] LAST_IDX = 4'hF;

   typedef enum logic [1:0] {IDLE, SCAN, OUT, DONE} state_e;
endpackage

// File: rtl/lut_1596_inv_scan_lut.sv
// lut_1596: 4-bit input to 1-bit output lookup; y=1 only for x in {4, 8, 10}.
module lut_1596 (
   input  logic [3:0] i_x,
   output logic       o_y
);
   localparam logic [15:0] TBL = 16'h0510;

   assign o_y = TBL[i_x];
endmodule

// File: rtl/lut_1596_inv_scan.sv
// Walks x = 0..15 one per cycle, emits every x with lut_1596(x) == target
// over valid/ready, then pulses done with the number of matches transferred.
module lut_1596_inv_scan
   import lut_1596_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             target_i,
   output logic [XW-1:0]    x_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] count_o
);
   state_e             r_state, w_state_nxt;
   logic [XW-1:0]      r_idx, w_idx_nxt;
   logic [XW-1:0]      r_x, w_x_nxt;
   logic               r_valid, w_valid_nxt;
   logic               r_done, w_done_nxt;
   logic [CNT_W-1:0]   r_count, w_count_nxt;
   logic               r_target, w_target_nxt;
   logic               w_y;
   logic               w_last;

   lut_1596 u_lut (
      .i_x (r_idx),
      .o_y (w_y)
   );

   assign w_last = (r_idx == LAST_IDX);

   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_x_nxt      = r_x;
      w_valid_nxt  = r_valid;
      w_done_nxt   = 1'b0;
      w_count_nxt  = r_count;
      w_target_nxt = r_target;
      unique case (r_state)
         IDLE: begin
            if (start_i) begin
               w_state_nxt  = SCAN;
               w_idx_nxt    = '0;
               w_count_nxt  = '0;
               w_target_nxt = target_i;
            end
         end
         SCAN: begin
            if (w_y == r_target) begin
               w_x_nxt     = r_idx;
               w_valid_nxt = 1'b1;
               w_state_nxt = OUT;
            end else if (w_last) begin
               w_state_nxt = DONE;
               w_done_nxt  = 1'b1;
            end else begin
               w_idx_nxt = r_idx + XW'(1);
            end
         end
         OUT: begin
            // idx still points at the emitted match; advance only after hand-off
            if (ready_i) begin
               w_valid_nxt = 1'b0;
               w_count_nxt = r_count + CNT_W'(1);
               if (w_last) begin
                  w_state_nxt = DONE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_idx_nxt   = r_idx + XW'(1);
                  w_state_nxt = SCAN;
               end
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_idx    <= '0;
         r_x      <= '0;
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
         r_count  <= '0;
         r_target <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         r_x      <= w_x_nxt;
         r_valid  <= w_valid_nxt;
         r_done   <= w_done_nxt;
         r_count  <= w_count_nxt;
         r_target <= w_target_nxt;
      end
   end

   assign x_o     = r_x;
   assign valid_o = r_valid;
   assign done_o  = r_done;
   assign count_o = r_count;
   assign busy_o  = (r_state != IDLE);
endmodule

// File: doc/lut_1596_inv_scan.md
Name: lut_1596_inv_scan

Overview:
Inverse-direction companion to the 4-bit lookup function lut_1596: it enumerates every 4-bit input x whose lut_1596 output equals a requested target bit. Matches are emitted one per valid/ready transfer in ascending order, followed by a done pulse and the match count. It sits beside lut_1596 for table self-check and for consumers that need the preimage set (target 1 -> {4, 8, 10}).

Parameters:
XW, 4, input width of the scanned function; fixed at 4 and not overridable in practice (lut_1596 is 4-bit).
CNT_W, 5, width of match counter; must hold 2**XW (16).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start_i  input  1  scan request; sampled only in IDLE.
target_i  input  1  y value to search for; latched when start accepted.
x_o  output  XW  matching input value.
valid_o  output  1  x_o holds a match.
ready_i  input  1  consumer accepts x_o; transfer when valid_o && ready_i at an edge.
busy_o  output  1  high in SCAN, OUT, DONE.
done_o  output  1  one-cycle pulse at scan completion.
count_o  output  CNT_W  number of matches transferred in the last or current scan.

Behaviour:
- Reset (rst=1 at an edge, any state including mid-scan): state=IDLE, idx=0, x_o=0, valid_o=0, done_o=0, count_o=0, target=0. In-flight match is discarded, not transferred.
- All outputs registered; lut_1596 evaluated combinationally on idx.
- IDLE: start_i=1 -> SCAN, idx=0, count_o=0, target<=target_i. start_i outside IDLE ignored.
- SCAN (one candidate per cycle): if lut(idx)==target -> x_o<=idx, valid_o<=1, OUT. Else if idx==15 -> DONE. Else idx<=idx+1.
- OUT: x_o and valid_o held stable while ready_i=0 (no timeout). On transfer: valid_o<=0, count_o<=count_o+1; idx==15 -> DONE, else idx<=idx+1, SCAN.
- DONE: done_o=1 for exactly this cycle; count_o final; next edge -> IDLE, done_o<=0. count_o holds until the next accepted start.
- Timing with ready_i=1, start sampled at edge E0: candidate k evaluated at edge E(1+k+stall); first match x=4 valid after E5; transfers at E6, E11, E14; done_o high after E19.
- Match at idx 15 (target=0): emitted, then DONE after its transfer; idx never wraps past 15.
- ready_i asserted while valid_o=0: no effect.
- start_i held high: re-triggers a new scan on the edge after DONE->IDLE (no back-to-back in the DONE cycle).
- count_o wrap impossible (max 16 < 2**CNT_W).

Decomposition:
- Package lut_1596_pkg: state enum (IDLE, SCAN, OUT, DONE), XW and CNT_W constants, LAST_IDX = 4'hF.
- One sub-module: instantiate lut_1596 (x=idx, y=lut result); no duplicate table in this block.

Test Plan:
- target=1, ready tied 1, start pulse -> x_o sequence 4, 8, 10 (valid after E5, E10, E13), done_o after E19, count_o=3.
- target=0, ready tied 1 -> 13 transfers: 0,1,2,3,5,6,7,9,11,12,13,14,15; count_o=13; last transfer x=15 then done_o.
- target=1, ready_i low for 7 cycles while x_o=8 -> x_o/valid_o stable for all 7 cycles, single transfer, total latency +7 cycles, count_o=3.
- start_i pulsed during SCAN and OUT -> ignored; target change mid-scan -> no effect; results identical to first scenario.
- rst asserted while valid_o=1 with x_o=8 -> next cycle IDLE, valid_o=0, count_o=0; new scan then yields 4, 8, 10.
- start_i held high continuously, target=1 -> scans repeat, each producing 4, 8, 10 and one done_o pulse; IDLE cycle between scans.
